// File: rtl/brc_seq.sv
// rtl/brc_seq.sv - multi-cycle MSB-first chunked branch comparator with valid/ready handshake
module brc_seq #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [2:0]       i_br_op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal,
    output logic             o_br_taken
);
    localparam int N  = XLEN / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q;
    logic [KW-1:0]     k_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2:0]        op_q;
    logic              decided_q, lt_q;

    logic [CHUNK-1:0]  a_k, b_k;
    logic              uns;
    logic              decided_d, lt_d, taken_d;

    always_comb begin
        uns = op_q[2] & op_q[1];
        a_k = a_q[int'(k_q) * CHUNK +: CHUNK];
        b_k = b_q[int'(k_q) * CHUNK +: CHUNK];
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        if (!uns && (k_q == KW'(N - 1))) begin
            a_k[CHUNK-1] = ~a_k[CHUNK-1];
            b_k[CHUNK-1] = ~b_k[CHUNK-1];
        end
        decided_d = decided_q;
        lt_d      = lt_q;
        if (!decided_q && (a_k != b_k)) begin
            decided_d = 1'b1;
            lt_d      = (a_k < b_k);
        end
        case (op_q)
            3'b000:         taken_d = ~decided_d;
            3'b001:         taken_d = decided_d;
            3'b100, 3'b110: taken_d = lt_d;
            3'b101, 3'b111: taken_d = ~lt_d;
            default:        taken_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            decided_q  <= 1'b0;
            lt_q       <= 1'b0;
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b0;
            o_br_taken <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_q       <= i_rs1_data;
                        b_q       <= i_rs2_data;
                        op_q      <= i_br_op;
                        decided_q <= 1'b0;
                        lt_q      <= 1'b0;
                        k_q       <= KW'(N - 1);
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    decided_q <= decided_d;
                    lt_q      <= lt_d;
                    if (k_q == '0) begin
                        o_br_less  <= lt_d;
                        o_br_equal <= ~decided_d;
                        o_br_taken <= taken_d;
                        state_q    <= DONE;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
endmodule
